// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants, HALT/RUN state type and operand-use helpers.
// Imported by the decode/hazard stage and its forwarding mux.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) ||
             (op == OP_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_OP) || (op == OP_STORE) ||
           (op == OP_BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [31:0] iw);
    logic [6:0] op;
    op = iw[6:0];
    return !((op == OP_STORE) || (op == OP_BRANCH) ||
             (op == OP_SYSTEM)) && (iw[11:7] != 5'd0);
  endfunction

endpackage

// File: rtl/rv32i_fwd_mux.sv
// Operand source select: lowest-index enabled forwarding match wins, else
// register file; x0 always reads 0. o_pend flags the chosen source as not ready.
module rv32i_fwd_mux #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3
) (
  input  logic [4:0]              i_rs,
  input  logic [XLEN-1:0]         i_rf_data,
  input  logic [NUM_FWD-1:0]      i_df_en,
  input  logic [5*NUM_FWD-1:0]    i_df_reg,
  input  logic [XLEN*NUM_FWD-1:0] i_df_data,
  input  logic [NUM_FWD-1:0]      i_df_pend,
  output logic [XLEN-1:0]         o_data,
  output logic                    o_pend
);

  // Walk oldest to youngest so the youngest match is the last assignment.
  always_comb begin
    o_data = i_rf_data;
    o_pend = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (i_df_en[i] && (i_df_reg[5*i +: 5] == i_rs)) begin
        o_data = i_df_data[XLEN*i +: XLEN];
        o_pend = i_df_pend[i];
      end
    end
    if (i_rs == 5'd0) begin
      o_data = '0;
      o_pend = 1'b0;
    end
  end

endmodule

// File: rtl/rv32i_id_hazard_stage.sv
// RV32I decode stage: operand forwarding, load-use stall, flush and EBREAK halt.
// Ports: IF inputs (valid/iw/pc/regfile data), forwarding bus df_*, EX register outputs.
module rv32i_id_hazard_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NUM_FWD     = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic [31:0]             iw_in,
  input  logic [31:0]             pc_in,
  input  logic [XLEN-1:0]         rs1_data_in,
  input  logic [XLEN-1:0]         rs2_data_in,
  input  logic                    flush_in,
  input  logic [NUM_FWD-1:0]      df_en,
  input  logic [5*NUM_FWD-1:0]    df_reg,
  input  logic [XLEN*NUM_FWD-1:0] df_data,
  input  logic [NUM_FWD-1:0]      df_pend,
  output logic [4:0]              rs1_reg,
  output logic [4:0]              rs2_reg,
  output logic                    stall_out,
  output logic                    valid_out,
  output logic                    wb_en_out,
  output logic [31:0]             pc_out,
  output logic [31:0]             iw_out,
  output logic [4:0]              wb_reg,
  output logic [XLEN-1:0]         rs1_data_out,
  output logic [XLEN-1:0]         rs2_data_out,
  output logic                    halted,
  output logic [STALL_CNT_W-1:0]  stall_cnt
);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic                   r_valid;
  logic                   r_wb_en;
  logic [31:0]            r_pc;
  logic [31:0]            r_iw;
  logic [4:0]             r_wb_reg;
  logic [XLEN-1:0]        r_rs1;
  logic [XLEN-1:0]        r_rs2;
  logic [STALL_CNT_W-1:0] r_cnt;

  logic [XLEN-1:0] w_rs1_fwd;
  logic [XLEN-1:0] w_rs2_fwd;
  logic            w_rs1_pend;
  logic            w_rs2_pend;
  logic            w_live;
  logic            w_hazard;
  logic            w_ebreak;
  logic            w_issue;

  assign rs1_reg = iw_in[19:15];
  assign rs2_reg = iw_in[24:20];

  rv32i_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .i_rs      (rs1_reg),
    .i_rf_data (rs1_data_in),
    .i_df_en   (df_en),
    .i_df_reg  (df_reg),
    .i_df_data (df_data),
    .i_df_pend (df_pend),
    .o_data    (w_rs1_fwd),
    .o_pend    (w_rs1_pend)
  );

  rv32i_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .i_rs      (rs2_reg),
    .i_rf_data (rs2_data_in),
    .i_df_en   (df_en),
    .i_df_reg  (df_reg),
    .i_df_data (df_data),
    .i_df_pend (df_pend),
    .o_data    (w_rs2_fwd),
    .o_pend    (w_rs2_pend)
  );

  // Flush outranks the hazard: a squashed instruction never stalls.
  assign w_live   = valid_in && !flush_in && (r_state == ST_RUN);
  assign w_hazard = w_live &&
    ((uses_rs1(iw_in[6:0]) && w_rs1_pend) ||
     (uses_rs2(iw_in[6:0]) && w_rs2_pend));
  assign w_ebreak = w_live && (iw_in == EBREAK);
  assign w_issue  = w_live && !w_hazard && !w_ebreak;

  assign stall_out = w_hazard && !reset;
  assign halted    = (r_state == ST_HALT);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN:  if (w_ebreak) w_state_nxt = ST_HALT;
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_wb_en  <= 1'b0;
      r_pc     <= '0;
      r_iw     <= NOP;
      r_wb_reg <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
    end else begin
      r_pc <= pc_in;
      if (w_issue) begin
        r_valid  <= 1'b1;
        r_wb_en  <= writes_rd(iw_in);
        r_iw     <= iw_in;
        r_wb_reg <= iw_in[11:7];
        r_rs1    <= w_rs1_fwd;
        r_rs2    <= w_rs2_fwd;
      end else begin
        r_valid  <= 1'b0;
        r_wb_en  <= 1'b0;
        r_iw     <= NOP;
        r_wb_reg <= '0;
        r_rs1    <= '0;
        r_rs2    <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (stall_out && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign valid_out    = r_valid;
  assign wb_en_out    = r_wb_en;
  assign pc_out       = r_pc;
  assign iw_out       = r_iw;
  assign wb_reg       = r_wb_reg;
  assign rs1_data_out = r_rs1;
  assign rs2_data_out = r_rs2;
  assign stall_cnt    = r_cnt;

endmodule
